// File: rtl/scan_mux_pkg.sv
// ---------------------------------------------------------------------------
// scan_mux_pkg
// Shared definitions for the scanning display multiplexer.
//   mode_e         : MODE_MANUAL (external select) / MODE_SCAN (auto-advance)
//   clog2          : ceiling log2. Used to size the select and prescaler.
//   idx_to_onehot  : returns one bit of the one-hot decode of an index.
// ---------------------------------------------------------------------------
package scan_mux_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  // Ceiling log2. An input of 1 gives 0; callers guarantee values >= 2.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // Bit bit_pos of the one-hot decode of idx. The caller loops over the
  // channel count, so the decode fits any CHANNELS without a fixed-width
  // intermediate vector.
  function automatic logic idx_to_onehot(input int idx, input int bit_pos);
    return (idx == bit_pos);
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// ---------------------------------------------------------------------------
// scan_prescaler
// Free-running 0..SCAN_DIV-1 counter that paces the channel advance in scan
// mode.
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high reset
//   clr    in   synchronous clear. Held high in manual mode so that scanning
//               always starts from a full period.
//   en     in   count enable. Low while frozen by hold.
//   tc     out  terminal count. High only while enabled at SCAN_DIV-1.
// ---------------------------------------------------------------------------
module scan_prescaler
  import scan_mux_pkg::*;
#(
  parameter  int SCAN_DIV = 16,
  localparam int CNT_W    = clog2(SCAN_DIV)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] count;

  // tc is gated by en, so a frozen prescaler sitting at its last value
  // never requests an advance. This is what lets hold beat terminal count.
  assign tc = en && (count == LAST);

  // The wrap is an explicit compare rather than natural overflow, so
  // SCAN_DIV values that are not a power of two still give the right period.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      if (tc) begin
        count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/scan_mux.sv
// ---------------------------------------------------------------------------
// scan_mux
// Registered N-channel multiplexer that feeds the 7-segment digit driver.
// In manual mode an external select picks the channel. In scan mode the
// channel steps every SCAN_DIV cycles.
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   data_in    in   CHANNELS*WIDTH; channel k = data_in[k*WIDTH +: WIDTH]
//   mode       in   0 = manual, 1 = scan
//   sel        in   manual channel select. Values past the last channel clamp.
//   hold       in   freezes the scan position (scan mode only)
//   out        out  registered data of the channel shown on ch_idx
//   ch_idx     out  current channel index
//   ch_onehot  out  one-hot of ch_idx (digit enables)
//   ch_tick    out  one-cycle pulse in the cycle after ch_idx changed
// ---------------------------------------------------------------------------
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter  int WIDTH    = 4,
  parameter  int CHANNELS = 4,
  parameter  int SCAN_DIV = 16,
  localparam int SEL_W    = clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      hold,
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          ch_idx,
  output logic [CHANNELS-1:0]       ch_onehot,
  output logic                      ch_tick
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CHANNELS - 1);

  logic                clr;
  logic                en;
  logic                tc;
  logic [SEL_W-1:0]    sel_clamped;
  logic [SEL_W-1:0]    idx_inc;
  logic [SEL_W-1:0]    idx_next;
  logic [CHANNELS-1:0] onehot_next;
  logic [WIDTH-1:0]    out_next;

  // The prescaler is held clear in manual mode. It only runs while scanning
  // and not held.
  assign clr = (mode == MODE_MANUAL);
  assign en  = (mode == MODE_SCAN) && !hold;

  scan_prescaler #(
    .SCAN_DIV (SCAN_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .en    (en),
    .tc    (tc)
  );

  // The select is widened before the compare so the clamp is also correct
  // when CHANNELS is not a power of two.
  always_comb begin
    sel_clamped = sel;
    if (int'(sel) >= CHANNELS) begin
      sel_clamped = LAST_IDX;
    end
  end

  // The increment wraps by compare to the last channel, not by natural
  // overflow.
  always_comb begin
    idx_inc = ch_idx + SEL_W'(1);
    if (ch_idx == LAST_IDX) begin
      idx_inc = '0;
    end
  end

  // Channel selection priority: manual select, then hold, then terminal
  // count. The hold check is redundant with the gated tc, but it keeps the
  // priority readable.
  always_comb begin
    idx_next = ch_idx;
    if (mode == MODE_MANUAL) begin
      idx_next = sel_clamped;
    end else if (hold) begin
      idx_next = ch_idx;
    end else if (tc) begin
      idx_next = idx_inc;
    end
  end

  // The one-hot and the data word are both derived from idx_next and
  // registered together with ch_idx. out therefore always belongs to the
  // digit that is currently enabled.
  always_comb begin
    onehot_next = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      onehot_next[k] = idx_to_onehot(int'(idx_next), k);
    end
  end

  assign out_next = data_in[int'(idx_next)*WIDTH +: WIDTH];

  // Output and index registers. ch_tick flags any change of index,
  // whichever mode caused it.
  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= '0;
      ch_idx    <= '0;
      ch_onehot <= CHANNELS'(1);
      ch_tick   <= 1'b0;
    end else begin
      out       <= out_next;
      ch_idx    <= idx_next;
      ch_onehot <= onehot_next;
      ch_tick   <= (idx_next != ch_idx);
    end
  end

endmodule
